bios_port_arbiter: RTL

Two-requester arbiter sharing the single read/write port B of the 4096×32 boot RAM. Requester M0 is the CPU-side bootloader access path; requester M1 is the debug/reload engine. The block registers the winning command onto the RAM port and routes the one-cycle-latency read data back to the owner. It supports round-robin arbitration, an optional lock for back-to-back ownership, and an optional write-protect window.

---
 rtl/bios_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bios_port_arbiter.sv
// rtl/bios_port_arbiter.sv - two-requester arbiter for boot RAM port B
//
// Purpose: round-robin arbitration between M0 (bootloader path) and M1
// (debug/reload engine) for the single RAM port B, with an optional lock
// for back-to-back ownership. The winning command is registered onto mem_*.
// Read data comes straight from the RAM and the rvalid pulse is steered to
// the owner, two cycles after the grant.
//
// Optional feature macro: BIOS_ARB_WRITE_PROTECT_EN
//   When defined, an M0 write to a word below PROT_LIMIT is issued as a read
//   and sets the sticky prot_err flag. When undefined, prot_err is tied to 0.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   mX_req/lock/addr/we/wdata       requester command (X = 0, 1)
//   mX_gnt                          combinational grant
//   mX_rvalid, mX_rdata             completion pulse and RAM read data
//   mem_en/we/addr/din, mem_dout    registered RAM port B command, RAM data
//   prot_err                        sticky blocked-write flag
module bios_port_arbiter #(
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] PROT_LIMIT = 'h100
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [3:0]            m0_we,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [3:0]            m1_we,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout,
  output logic                  prot_err
);

  logic last_owner;
  logic locked;
  logic s1_valid, s1_id;
  logic s2_valid, s2_id;

  logic                  any_gnt;
  logic                  gnt_lock;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [3:0]            gnt_we;
  logic [31:0]           gnt_wdata;
  logic [3:0]            issue_we;
  logic                  prot_hit;

  // While locked only the holder may win; if the holder has dropped req,
  // nobody is granted this cycle and the lock falls away at the edge.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (locked) begin
      if (last_owner) m1_gnt = m1_req;
      else            m0_gnt = m0_req;
    end else if (m0_req && m1_req) begin
      if (last_owner) m0_gnt = 1'b1;
      else            m1_gnt = 1'b1;
    end else begin
      m0_gnt = m0_req;
      m1_gnt = m1_req;
    end
  end

  assign any_gnt   = m0_gnt | m1_gnt;
  assign gnt_lock  = m1_gnt ? m1_lock  : m0_lock;
  assign gnt_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign gnt_we    = m1_gnt ? m1_we    : m0_we;
  assign gnt_wdata = m1_gnt ? m1_wdata : m0_wdata;

  assign prot_hit = m0_gnt && (m0_we != 4'b0000) && (m0_addr < PROT_LIMIT);

`ifdef BIOS_ARB_WRITE_PROTECT_EN
  // A blocked write is still granted and completes, but as a read.
  assign issue_we = prot_hit ? 4'b0000 : gnt_we;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         prot_err <= 1'b0;
    else if (prot_hit) prot_err <= 1'b1;
  end
`else
  logic unused_prot_hit;
  assign unused_prot_hit = prot_hit;
  assign issue_we        = gnt_we;
  assign prot_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_owner <= 1'b1;
      locked     <= 1'b0;
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      s2_valid   <= 1'b0;
      s2_id      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 4'b0000;
      mem_addr   <= '0;
      mem_din    <= 32'h0;
    end else begin
      // Stage 2 lines up with the cycle in which mem_dout is valid.
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      if (any_gnt) begin
        last_owner <= m1_gnt;
        locked     <= gnt_lock;
        s1_valid   <= 1'b1;
        s1_id      <= m1_gnt;
        mem_en     <= 1'b1;
        mem_we     <= issue_we;
        mem_addr   <= gnt_addr;
        mem_din    <= gnt_wdata;
      end else begin
        // No grant while locked means the holder dropped req.
        locked   <= 1'b0;
        s1_valid <= 1'b0;
        mem_en   <= 1'b0;
        mem_we   <= 4'b0000;
      end
    end
  end

  assign m0_rvalid = s2_valid & ~s2_id;
  assign m1_rvalid = s2_valid &  s2_id;
  assign m0_rdata  = mem_dout;
  assign m1_rdata  = mem_dout;

endmodule
